// File: rtl/ahb_ext_ram.sv
// rtl/ahb_ext_ram.sv - AHB-Lite external RAM subordinate with programmable wait states and ERROR response
module ahb_ext_ram #(
    parameter int                 AHBW       = 64,
    parameter int                 PA_BITS    = 32,
    parameter int                 DEPTH_LOG2 = 12,
    parameter logic [PA_BITS-1:0] BASE       = 32'h8000_0000,
    parameter int                 WAIT       = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               HSELEXT,
    input  logic [PA_BITS-1:0] HADDR,
    input  logic [AHBW-1:0]    HWDATA,
    input  logic [AHBW/8-1:0]  HWSTRB,
    input  logic               HWRITE,
    input  logic [2:0]         HSIZE,
    input  logic [2:0]         HBURST,
    input  logic [3:0]         HPROT,
    input  logic               HMASTLOCK,
    input  logic [1:0]         HTRANS,
    input  logic               HREADY,
    output logic [AHBW-1:0]    HRDATAEXT,
    output logic               HREADYEXT,
    output logic               HRESPEXT
);
    localparam int BYTES = AHBW / 8;
    localparam int OFF   = $clog2(BYTES);
    localparam int IW    = DEPTH_LOG2;
    localparam logic [PA_BITS:0] SPAN     = (PA_BITS+1)'(1) << (DEPTH_LOG2 + OFF);
    localparam logic [PA_BITS:0] LIMIT    = {1'b0, BASE} + SPAN;
    localparam logic [3:0]       CNT_INIT = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAITST,
        S_RESP,
        S_ERR1,
        S_ERR2
    } state_t;

    state_t          state, state_n;
    logic [3:0]      cnt, cnt_n;
    logic [IW-1:0]   idx_q;
    logic            write_q;
    logic [AHBW-1:0] mem [2**IW];

    logic            can_accept, accept, legal;
    logic            in_range, aligned, size_ok;
    logic [7:0]      size_mask;
    logic [IW-1:0]   haddr_idx, rd_idx;
    logic            rd_dir, load_rd, commit;
    logic [AHBW-1:0] rd_word;

    wire unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0]};

    assign can_accept = (state == S_IDLE) || (state == S_RESP) || (state == S_ERR2);
    assign accept     = can_accept && HSELEXT && HREADY && HTRANS[1];

    assign in_range  = ({1'b0, HADDR} >= {1'b0, BASE}) && ({1'b0, HADDR} < LIMIT);
    assign size_mask = (8'd1 << HSIZE) - 8'd1;
    assign aligned   = (HADDR[7:0] & size_mask) == 8'd0;
    assign size_ok   = HSIZE <= 3'(OFF);
    assign legal     = in_range && aligned && size_ok;
    assign haddr_idx = HADDR[IW+OFF-1:OFF];

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        HREADYEXT = 1'b1;
        HRESPEXT  = 1'b0;
        case (state)
            S_WAITST: begin
                HREADYEXT = 1'b0;
                if (cnt == 4'd0) state_n = S_RESP;
                else             cnt_n   = cnt - 4'd1;
            end
            S_ERR1: begin
                HREADYEXT = 1'b0;
                HRESPEXT  = 1'b1;
                state_n   = S_ERR2;
            end
            S_ERR2: begin
                HRESPEXT = 1'b1;
                state_n  = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
        if (accept) begin
            if (!legal) begin
                state_n = S_ERR1;
            end else if (WAIT == 0) begin
                state_n = S_RESP;
            end else begin
                state_n = S_WAITST;
                cnt_n   = CNT_INIT;
            end
        end
    end

    // A write commits on the edge leaving RESP; a read entering RESP on that same edge sees it.
    assign commit  = (state == S_RESP) && write_q;
    assign rd_idx  = accept ? haddr_idx : idx_q;
    assign rd_dir  = accept ? !HWRITE : !write_q;
    assign load_rd = (state_n == S_RESP) && rd_dir;

    always_comb begin
        rd_word = mem[rd_idx];
        if (commit && (rd_idx == idx_q)) begin
            for (int i = 0; i < BYTES; i++) begin
                if (HWSTRB[i]) rd_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            idx_q     <= '0;
            write_q   <= 1'b0;
            HRDATAEXT <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept && legal) begin
                idx_q   <= haddr_idx;
                write_q <= HWRITE;
            end
            if (state_n == S_ERR1)
                HRDATAEXT <= '0;
            else if (load_rd)
                HRDATAEXT <= rd_word;
        end
    end

    // Reset forces state to IDLE asynchronously, so an in-flight write never commits.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int i = 0; i < BYTES; i++) begin
                if (HWSTRB[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end
endmodule

// File: doc/ahb_ext_ram.md
# ahb_ext_ram

AHB-Lite subordinate that responds to the SoC's external bus port: it consumes the manager-side signals the core drives (HSELEXT, HADDR, HWDATA, HWSTRB, HWRITE, HSIZE, HTRANS, HREADY) and produces HRDATAEXT, HREADYEXT and HRESPEXT. It models a word-organised external RAM with a programmable number of wait states and a two-cycle ERROR response for illegal accesses. It serves as the simulation/FPGA-side external memory, and as the protocol-compliance target for the uncore's external-port path.

## Interface
- AHBW, 64: data bus width in bits (32 or 64).
- PA_BITS, 32: physical address width.
- DEPTH_LOG2, 12: log2 of the number of AHBW-bit words.
- BASE, 32'h8000_0000: byte base address, aligned to the region size.
- WAIT, 2: wait states per data phase, 0..15.
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- HSELEXT  in  1  subordinate select.
- HADDR  in  PA_BITS  address-phase byte address.
- HWDATA  in  AHBW  data-phase write data.
- HWSTRB  in  AHBW/8  data-phase byte strobes.
- HWRITE  in  1  address-phase direction (1 = write).
- HSIZE  in  3  transfer size, log2 bytes.
- HBURST, HPROT, HMASTLOCK  in  3/4/1  accepted and ignored.
- HTRANS  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- HREADY  in  1  bus-level ready; an address phase is sampled only when this is 1.
- HRDATAEXT  out  AHBW  read data.
- HREADYEXT  out  1  subordinate ready (HREADYOUT).
- HRESPEXT  out  1  0 OKAY, 1 ERROR.

## Operation
- Accept: the transfer is accepted at a rising edge where HSELEXT & HREADY & HTRANS[1] = 1. Latch HADDR, HWRITE, HSIZE.
- Legal access: all three conditions hold.
  - BASE ≤ HADDR < BASE + 2^DEPTH_LOG2·AHBW/8.
  - HADDR aligned to 2^HSIZE.
  - 2^HSIZE ≤ AHBW/8.
- Word index = HADDR[DEPTH_LOG2+log2(AHBW/8)-1 : log2(AHBW/8)].
- States:
  - IDLE: HREADYEXT=1, HRESPEXT=0.
  - WAITST: HREADYEXT=0, down-counter cnt.
  - RESP: HREADYEXT=1, HRESPEXT=0.
  - ERR1: HREADYEXT=0, HRESPEXT=1.
  - ERR2: HREADYEXT=1, HRESPEXT=1.
- Transitions on accept (from IDLE, RESP or ERR2):
  - Illegal access → ERR1.
  - Legal access with WAIT=0 → RESP.
  - Legal access with WAIT>0 → WAITST, cnt=WAIT-1.
- Other transitions:
  - WAITST: if cnt=0 → RESP, else cnt-1.
  - ERR1 → ERR2, unconditionally.
  - RESP or ERR2 with no accept → IDLE.
  - IDLE with no accept → IDLE.
  - IDLE/BUSY transfers and unselected cycles are not accepted; they get zero-wait OKAY.
- Reads: HRDATAEXT loads mem[index] at the edge entering RESP. The address comes from HADDR when entering from an accept (WAIT=0), otherwise from the latched address. HRDATAEXT holds its value outside RESP. ERR1 entry loads 0.
- Writes: in RESP, mem[index] byte lane i takes HWDATA lane i where HWSTRB[i]=1. The write commits at the edge ending RESP. A write that errors never modifies memory.
- Bypass: if a read is accepted at the same edge that commits a write to the same index, the strobed write bytes are forwarded into HRDATAEXT. Unstrobed bytes come from memory.
- Byte lanes are not shifted: subword reads return the full word, and the manager selects lanes.
- HBURST is ignored; every beat is an independent single transfer.
- Memory contents are not reset.

## Timing
- Reset values: state IDLE, cnt 0, HREADYEXT=1, HRESPEXT=0, HRDATAEXT=0.
- Data phase lasts WAIT+1 cycles: HREADYEXT is low for exactly WAIT cycles, then high for one.
- Back-to-back pipelined transfers at WAIT=0 sustain one transfer per cycle.
- Error response is exactly two cycles (ERR1, ERR2); the next transfer may be accepted in ERR2.
- Reset asserted mid-transfer takes effect immediately, with no clock required. The pending write is dropped and outputs take reset values.
- HWDATA/HWSTRB are sampled only in the RESP cycle; their values during WAITST are don't-care.

## Test plan
- WAIT=0: write 64'h1122334455667788, HWSTRB=8'hFF to BASE+0x10, then read BASE+0x10.
  - HREADYEXT never drops.
  - HRDATAEXT = 64'h1122334455667788 in the read's data phase.
- WAIT=0 pipelined:
  - Preload 64'hAAAAAAAAAAAAAAAA at BASE+0x20.
  - Write 64'h0000000012345678 with HWSTRB=8'h0F, then a read of the same address in the next address phase.
  - Read returns 64'hAAAAAAAA12345678 (bypass).
- WAIT=3: read BASE+0x10 → HREADYEXT low exactly 3 cycles, then high one cycle with the stored data, HRESPEXT=0.
- Write to BASE-8 → ERR1 (HREADYEXT=0, HRESPEXT=1) then ERR2 (1,1), then IDLE. A follow-up read of BASE+0x10 shows the word unchanged.
- HSIZE=2 at BASE+0x2 → two-cycle ERROR. HTRANS=BUSY with HSELEXT=1 → HREADYEXT=1, HRESPEXT=0, state stays IDLE.
- WAIT=3 write to BASE+0x30, reset pulsed in the second WAITST cycle.
  - Outputs are 1/0/0 immediately.
  - A later read of BASE+0x30 returns the old contents.
